// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter/sequencer for the single-ported data RAM.
// Two requesters (m0 = CPU mem stage, m1 = loader/debug) share one RAM.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   mN_req/we/addr/wdata_i  requester N transaction, held until mN_gnt_o
//   mN_gnt_o                accept (combinational, IDLE only)
//   mN_rvalid/rdata/err_o   one-cycle completion with read data / error
//   ram_*                   RAM strobes, address, write data, read data, error
module dmem_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int RD_LAT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_err_o,
    output logic              ram_r_en_o,
    output logic              ram_w_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic              ram_err_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] LAT = 4'(RD_LAT);

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
            id_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            id_q       <= id_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        id_d       = id_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        m0_gnt_o   = 1'b0;
        m1_gnt_o   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // m0 wins when alone or when m1 was served last
                if (m0_req_i && (!m1_req_i || last_gnt_q)) begin
                    m0_gnt_o = 1'b1;
                end else if (m1_req_i) begin
                    m1_gnt_o = 1'b1;
                end
                if (m0_gnt_o || m1_gnt_o) begin
                    id_d       = m1_gnt_o;
                    last_gnt_d = m1_gnt_o;
                    we_d       = m1_gnt_o ? m1_we_i : m0_we_i;
                    addr_d     = m1_gnt_o ? m1_addr_i : m0_addr_i;
                    wdata_d    = m1_gnt_o ? m1_wdata_i : m0_wdata_i;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    // writes and faulted reads return zero data
                    rdata_d = (we_q || ram_err_i) ? '0 : ram_rdata_i;
                    err_d   = ram_err_i;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic resp;
    assign resp = (state_q == S_RESP);

    assign ram_r_en_o  = (state_q == S_ISSUE) && !we_q;
    assign ram_w_en_o  = (state_q == S_ISSUE) && we_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;

    assign m0_rvalid_o = resp && !id_q;
    assign m1_rvalid_o = resp && id_q;
    assign m0_rdata_o  = m0_rvalid_o ? rdata_q : '0;
    assign m1_rdata_o  = m1_rvalid_o ? rdata_q : '0;
    assign m0_err_o    = m0_rvalid_o && err_q;
    assign m1_err_o    = m1_rvalid_o && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance a (RD_LAT=0) with a RAM model,
// instance b (RD_LAT=3) with bench-driven read data.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        id;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    localparam logic [63:0] WD   = 64'h1122334455667788;
    localparam logic [63:0] GOOD = 64'h0123456789ABCDEF;
    localparam logic [63:0] BAD  = 64'hBAD0BAD0BAD0BAD0;

    function automatic logic [63:0] init_val(int i);
        return {48'hA5A5_0000_0000, 16'(i)};
    endfunction

    // ---------------- instance a ----------------
    logic        a_rst, mem_init;
    logic        a_m0_req, a_m0_we, a_m0_gnt, a_m0_rvalid, a_m0_err;
    logic [63:0] a_m0_addr, a_m0_wdata, a_m0_rdata;
    logic        a_m1_req, a_m1_we, a_m1_gnt, a_m1_rvalid, a_m1_err;
    logic [63:0] a_m1_addr, a_m1_wdata, a_m1_rdata;
    logic        a_r_en, a_w_en, a_err;
    logic [63:0] a_addr, a_wdata, a_rdata;
    logic [63:0] mem [0:15];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
        end else if (a_w_en) begin
            mem[a_addr[6:3]] <= a_wdata;
        end
    end
    assign a_rdata = mem[a_addr[6:3]];

    dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .RD_LAT(0)) u_a (
        .clk_i(clk), .rst_i(a_rst),
        .m0_req_i(a_m0_req), .m0_we_i(a_m0_we),
        .m0_addr_i(a_m0_addr), .m0_wdata_i(a_m0_wdata),
        .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rvalid),
        .m0_rdata_o(a_m0_rdata), .m0_err_o(a_m0_err),
        .m1_req_i(a_m1_req), .m1_we_i(a_m1_we),
        .m1_addr_i(a_m1_addr), .m1_wdata_i(a_m1_wdata),
        .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rvalid),
        .m1_rdata_o(a_m1_rdata), .m1_err_o(a_m1_err),
        .ram_r_en_o(a_r_en), .ram_w_en_o(a_w_en),
        .ram_addr_o(a_addr), .ram_wdata_o(a_wdata),
        .ram_rdata_i(a_rdata), .ram_err_i(a_err)
    );

    // ---------------- instance b ----------------
    logic        b_rst;
    logic        b_m0_req, b_m0_we, b_m0_gnt, b_m0_rvalid, b_m0_err;
    logic [63:0] b_m0_addr, b_m0_wdata, b_m0_rdata;
    logic        b_m1_req, b_m1_we, b_m1_gnt, b_m1_rvalid, b_m1_err;
    logic [63:0] b_m1_addr, b_m1_wdata, b_m1_rdata;
    logic        b_r_en, b_w_en, b_err;
    logic [63:0] b_addr, b_wdata, b_rdata;

    dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .RD_LAT(3)) u_b (
        .clk_i(clk), .rst_i(b_rst),
        .m0_req_i(b_m0_req), .m0_we_i(b_m0_we),
        .m0_addr_i(b_m0_addr), .m0_wdata_i(b_m0_wdata),
        .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid),
        .m0_rdata_o(b_m0_rdata), .m0_err_o(b_m0_err),
        .m1_req_i(b_m1_req), .m1_we_i(b_m1_we),
        .m1_addr_i(b_m1_addr), .m1_wdata_i(b_m1_wdata),
        .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid),
        .m1_rdata_o(b_m1_rdata), .m1_err_o(b_m1_err),
        .ram_r_en_o(b_r_en), .ram_w_en_o(b_w_en),
        .ram_addr_o(b_addr), .ram_wdata_o(b_wdata),
        .ram_rdata_i(b_rdata), .ram_err_i(b_err)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors: pop one expectation per completion pulse.
    always @(negedge clk) begin
        chk("a_gnt_excl", 64'(a_m0_gnt & a_m1_gnt), 0);
        if (a_m0_rvalid || a_m1_rvalid) begin
            if (qa.size() == 0) begin
                chk("a_rv_unexpected", {62'b0, a_m1_rvalid, a_m0_rvalid}, 0);
            end else begin
                ea = qa.pop_front();
                chk("a_rv_excl", 64'(a_m0_rvalid & a_m1_rvalid), 0);
                chk("a_rv_id", 64'(a_m1_rvalid), 64'(ea.id));
                chk("a_rdata", a_m1_rvalid ? a_m1_rdata : a_m0_rdata, ea.data);
                chk("a_err", 64'(a_m1_rvalid ? a_m1_err : a_m0_err), 64'(ea.err));
                chk("a_other_quiet",
                    a_m1_rvalid ? (a_m0_rdata | 64'(a_m0_err))
                                : (a_m1_rdata | 64'(a_m1_err)), 0);
            end
        end else begin
            chk("a_idle_outs", a_m0_rdata | a_m1_rdata | 64'(a_m0_err | a_m1_err), 0);
        end
    end

    always @(negedge clk) begin
        chk("b_gnt_excl", 64'(b_m0_gnt & b_m1_gnt), 0);
        if (b_m0_rvalid || b_m1_rvalid) begin
            if (qb.size() == 0) begin
                chk("b_rv_unexpected", {62'b0, b_m1_rvalid, b_m0_rvalid}, 0);
            end else begin
                eb = qb.pop_front();
                chk("b_rv_id", 64'(b_m1_rvalid), 64'(eb.id));
                chk("b_rdata", b_m1_rvalid ? b_m1_rdata : b_m0_rdata, eb.data);
                chk("b_err", 64'(b_m1_rvalid ? b_m1_err : b_m0_err), 64'(eb.err));
            end
        end
    end

    // Drive one instance-a transaction; returns at the negedge of its RESP cycle.
    task automatic a_txn(bit id, bit we, logic [63:0] addr, exp_t e);
        @(posedge clk); #1;
        if (id) begin
            a_m1_req = 1; a_m1_we = we; a_m1_addr = addr;
        end else begin
            a_m0_req = 1; a_m0_we = we; a_m0_addr = addr;
        end
        qa.push_back(e);
        @(negedge clk);
        chk("a_txn_gnt", 64'(id ? a_m1_gnt : a_m0_gnt), 1);
        @(posedge clk); #1;
        a_m0_req = 0; a_m1_req = 0;
        repeat (3) @(negedge clk);
    endtask

    int n, last, c;

    initial begin
        a_rst = 1; b_rst = 1; mem_init = 1;
        a_m0_req = 0; a_m0_we = 0; a_m0_addr = 0; a_m0_wdata = 0;
        a_m1_req = 0; a_m1_we = 0; a_m1_addr = 0; a_m1_wdata = 0;
        b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0;
        b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0;
        a_err = 0; b_err = 0; b_rdata = BAD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_strobes", 64'({a_r_en, a_w_en, a_m0_rvalid, a_m1_rvalid}), 0);
        chk("rst_a_addr", a_addr | a_wdata, 0);
        chk("rst_b_strobes", 64'({b_r_en, b_w_en, b_m0_rvalid, b_m1_rvalid}), 0);
        @(posedge clk); #1;
        a_rst = 0; b_rst = 0; mem_init = 0;

        // Test 1: m0 write 0x10
        @(posedge clk); #1;
        a_m0_req = 1; a_m0_we = 1; a_m0_addr = 64'h10; a_m0_wdata = WD;
        qa.push_back('{1'b0, 64'h0, 1'b0});
        @(negedge clk);
        chk("t1_gnt0", 64'(a_m0_gnt), 1);
        chk("t1_gnt1", 64'(a_m1_gnt), 0);
        chk("t1_idle_wen", 64'(a_w_en), 0);
        @(posedge clk); #1;
        a_m0_req = 0;
        @(negedge clk);
        chk("t1_issue_wen", 64'({a_w_en, a_r_en}), 2'b10);
        chk("t1_issue_addr", a_addr, 64'h10);
        chk("t1_issue_wdata", a_wdata, WD);
        @(negedge clk);
        chk("t1_wait_wen", 64'(a_w_en), 0);
        @(negedge clk);
        chk("t1_resp_rv", 64'({a_m1_rvalid, a_m0_rvalid}), 2'b01);
        @(negedge clk);
        chk("t1_after_rv", 64'(a_m0_rvalid), 0);

        // Test 2: m1 read back 0x10
        @(posedge clk); #1;
        a_m1_req = 1; a_m1_we = 0; a_m1_addr = 64'h10;
        qa.push_back('{1'b1, WD, 1'b0});
        @(negedge clk);
        chk("t2_gnt", 64'({a_m1_gnt, a_m0_gnt}), 2'b10);
        @(posedge clk); #1;
        a_m1_req = 0;
        @(negedge clk);
        chk("t2_issue_ren", 64'({a_r_en, a_w_en}), 2'b10);
        @(negedge clk);
        chk("t2_wait_ren", 64'(a_r_en), 0);
        @(negedge clk);
        chk("t2_resp_rv", 64'({a_m1_rvalid, a_m0_rvalid}), 2'b10);
        @(negedge clk);

        // Test 3: both requesting from reset, round robin
        @(posedge clk); #1;
        a_rst = 1;
        a_m0_req = 1; a_m0_we = 0; a_m0_addr = 64'h10;
        a_m1_req = 1; a_m1_we = 0; a_m1_addr = 64'h18;
        @(posedge clk); #1;
        a_rst = 0;
        n = 0; last = 0;
        for (c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (a_m0_gnt || a_m1_gnt) begin
                chk("t3_rr_order", 64'(a_m1_gnt), 64'(n % 2));
                if (n > 0) chk("t3_rr_gap", 64'(c - last), 4);
                last = c;
                if (n % 2 == 1) qa.push_back('{1'b1, init_val(3), 1'b0});
                else            qa.push_back('{1'b0, WD, 1'b0});
                n++;
            end
        end
        chk("t3_rr_count", 64'(n), 4);
        @(posedge clk); #1;
        a_m0_req = 0; a_m1_req = 0;
        repeat (5) @(negedge clk);

        // Test 5: read with RAM error, then clean read
        a_err = 1;
        a_txn(1'b0, 1'b0, 64'h10, '{1'b0, 64'h0, 1'b1});
        chk("t5_err_flag", 64'({a_m0_rvalid, a_m0_err}), 2'b11);
        chk("t5_err_rdata", a_m0_rdata, 0);
        a_err = 0;
        a_txn(1'b1, 1'b0, 64'h10, '{1'b1, WD, 1'b0});
        chk("t5_clean_err", 64'(a_m1_err), 0);

        // Reset landing in ISSUE drops the strobe at once
        @(posedge clk); #1;
        a_m0_req = 1; a_m0_we = 0; a_m0_addr = 64'h10;
        @(posedge clk); #1;
        a_m0_req = 0;
        chk("t6a_issue_ren", 64'(a_r_en), 1);
        a_rst = 1;
        #1;
        chk("t6a_rst_ren", 64'({a_r_en, a_w_en}), 0);
        @(posedge clk); #1;
        a_rst = 0;
        repeat (4) @(negedge clk);

        // Test 4: RD_LAT=3 read, data valid only in last WAIT cycle
        @(posedge clk); #1;
        b_m0_req = 1; b_m0_we = 0; b_m0_addr = 64'h40; b_rdata = BAD;
        qb.push_back('{1'b0, GOOD, 1'b0});
        @(negedge clk);
        chk("t4_gnt", 64'(b_m0_gnt), 1);
        @(posedge clk); #1;
        b_m0_req = 0;
        @(negedge clk);
        chk("t4_issue_ren", 64'(b_r_en), 1);
        chk("t4_issue_addr", b_addr, 64'h40);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_wait_ren", 64'(b_r_en), 0);
            chk("t4_wait_addr", b_addr, 64'h40);
            chk("t4_wait_rv", 64'(b_m0_rvalid), 0);
            if (i == 3) b_rdata = GOOD;
        end
        @(negedge clk);
        chk("t4_resp_rv", 64'(b_m0_rvalid), 1);
        chk("t4_resp_data", b_m0_rdata, GOOD);
        @(negedge clk);
        chk("t4_after_rv", 64'(b_m0_rvalid), 0);

        // Test 6: reset during WAIT aborts, then m0 wins the tie
        @(posedge clk); #1;
        b_m0_req = 1; b_m0_addr = 64'h48;
        @(negedge clk);
        chk("t6_gnt", 64'(b_m0_gnt), 1);
        @(posedge clk); #1;
        b_m0_req = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_rst = 1;
        #1;
        chk("t6_rst_strobes", 64'({b_r_en, b_w_en, b_m0_rvalid, b_m1_rvalid}), 0);
        chk("t6_rst_addr", b_addr, 0);
        repeat (3) @(posedge clk);
        #1;
        b_rst = 0;
        b_m0_req = 1; b_m0_addr = 64'h40;
        b_m1_req = 1; b_m1_addr = 64'h50;
        qb.push_back('{1'b0, GOOD, 1'b0});
        @(negedge clk);
        chk("t6_tie_gnt", 64'({b_m1_gnt, b_m0_gnt}), 2'b01);
        @(posedge clk); #1;
        b_m0_req = 0; b_m1_req = 0;
        repeat (8) @(negedge clk);

        chk("qa_drained", 64'(qa.size()), 0);
        chk("qb_drained", 64'(qb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
